ctrl_unit_param: RTL and testbench
==================================

CTRL_UNIT_PARAM -- requirements
Module: ctrl_unit_param

Interface
REQ-001 Parameter Pa, default 8: activation precision in bits.
REQ-002 Parameter Pw, default 4: weight precision in bits.
REQ-003 Parameter MNO, default 288: maximum MAC operations per output.
REQ-004 Parameter MNV, default 224*224: maximum output positions per layer.
REQ-005 Parameter NW, default 8: number of weight-register slots (filter groups); must be at least 1.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 core_stall_n  input  1  0 freezes the FSM and all counters; 1 runs them.
REQ-009 start  input  1  starts a layer, sampled only in IDLE.
REQ-010 cfg_valid  input  1  config write strobe, sampled only in IDLE.
REQ-011 cfg_max_ops  input  $clog2(MNO)  last MAC index (count = value+1).
REQ-012 cfg_max_quant  input  $clog2(Pa*Pw)  last quantisation index (count = value+1).
REQ-013 cfg_fil_groups  input  $clog2(NW+1)  active filter groups; 0 is treated as 1, values above NW are saturated to NW.
REQ-014 cfg_max_vol  input  $clog2(MNV)  last output-position index (count = value+1).
REQ-015 cfg_relu_en  input  1  enables the RELU stage.
REQ-016 cfg_ready  output  1  high in IDLE.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 act_load, wei_load, mac_en, acc_clr, quant_en, relu_en, wb, done  output  1 each  datapath strobes.
REQ-019 wei_reg_en  output  NW  one-hot enable for the weight-register slot being loaded.
REQ-020 fil_idx  output  $clog2(NW+1)  current filter group index.
REQ-021 vol_idx  output  $clog2(MNV)  current output position index.

Function
REQ-022 Configuration: the SHALL latch all cfg_* fields on a cycle with cfg_valid=1 in IDLE; cfg_valid outside IDLE SHALL be ignored.
REQ-023 FSM states SHALL be IDLE, LOAD_ACT, LOAD_WEI, MAC, QUANT, RELU, WB and DONE; every state lasts one cycle unless a counter is stated below.
REQ-024 IDLE -> LOAD_ACT: start=1 and core_stall_n=1; act_load=1 and acc_clr=1 SHALL assert in LOAD_ACT, one cycle after start.
REQ-025 LOAD_ACT -> LOAD_WEI; in LOAD_WEI, wei_load=1 and wei_reg_en SHALL be one-hot at bit fil_idx for one cycle.
REQ-026 LOAD_WEI -> MAC: mac_en=1 SHALL stay high for exactly cfg_max_ops+1 cycles, driven by an op counter that runs 0..cfg_max_ops.
REQ-027 MAC -> QUANT: quant_en=1 SHALL stay high for cfg_max_quant+1 cycles.
REQ-028 QUANT -> RELU if cfg_relu_en=1 (relu_en=1 for 1 cycle), else QUANT -> WB directly.
REQ-029 In WB, wb=1 and acc_clr=1 SHALL assert for 1 cycle.
REQ-030 Exit from WB, in priority order:
  - fil_idx < groups-1: fil_idx+1, go to LOAD_WEI.
  - else vol_idx < cfg_max_vol: fil_idx to 0, vol_idx+1, go to LOAD_ACT.
  - else go to DONE.
REQ-031 DONE SHALL assert done=1 for 1 cycle, then go to IDLE; counters SHALL clear on IDLE entry.
REQ-032 When core_stall_n=0, state, counters and all strobe outputs (act_load..done, wei_reg_en) SHALL hold their values; they resume on the next cycle with core_stall_n=1, with no cycle lost or repeated.
REQ-033 All strobes SHALL be registered outputs, and no two of act_load, wei_load, mac_en, quant_en, relu_en, wb, done SHALL be high together.
REQ-034 Counters SHALL never wrap: each compares against its inclusive terminal value.

Reset
REQ-035 With rst_n=0, the FSM SHALL go to IDLE immediately, all counters, indices and strobes SHALL be 0, and config registers SHALL reset to 0 (relu disabled); cfg_ready SHALL be 1.
REQ-036 Reset asserted mid-layer SHALL abort the layer with no done pulse, and the block SHALL accept a new cfg_valid/start after release.

Verification
REQ-037 Min config: ops=0, quant=0, groups=1, vol=0, relu=0, then start. Required: act_load at t+1, wei_load t+2, mac_en t+3, quant_en t+4, wb t+5, done t+6, idle t+7.
REQ-038 NW=8, groups=3, vol=1, ops=4, quant=3, relu=1. Required: wei_reg_en sequence 01,02,04,01,02,04; 6 wb pulses; 30 mac_en cycles; 6 relu_en; 1 done.
REQ-039 groups=0 and groups=12 (NW=8). Required: 1 and 8 groups processed per position respectively.
REQ-040 core_stall_n=0 for 5 cycles in the middle of MAC. Required: outputs frozen during the stall, and total mac_en-high cycles (excluding stall) still equal ops+1.
REQ-041 rst_n pulse during QUANT. Required: all outputs 0 asynchronously, no done pulse; a later run completes normally.
REQ-042 cfg_valid while busy with different values. Required: ignored; the current run uses the latched config.

Source files
------------

// File: rtl/ctrl_unit_param.sv
// Layer-sequencing control unit for a MAC datapath.
// For each output position it loads activations once, then walks the active filter groups.
// Each group runs LOAD_WEI, MAC, QUANT, optional RELU and WB.
// After the last position it pulses done and returns to IDLE.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   core_stall_n      0 freezes state, counters and strobes
//   start, cfg_valid  layer start / config write strobe (both sampled only in IDLE)
//   cfg_*             layer configuration (terminal indices, group count, relu enable)
//   cfg_ready, busy   IDLE / non-IDLE status
//   act_load..done    registered one-cycle datapath strobes
//   wei_reg_en        one-hot weight-register slot enable during LOAD_WEI
//   fil_idx, vol_idx  current filter group and output position
module ctrl_unit_param #(
  parameter int unsigned Pa  = 8,
  parameter int unsigned Pw  = 4,
  parameter int unsigned MNO = 288,
  parameter int unsigned MNV = 224 * 224,
  parameter int unsigned NW  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      core_stall_n,
  input  logic                      start,
  input  logic                      cfg_valid,
  input  logic [$clog2(MNO)-1:0]    cfg_max_ops,
  input  logic [$clog2(Pa*Pw)-1:0]  cfg_max_quant,
  input  logic [$clog2(NW+1)-1:0]   cfg_fil_groups,
  input  logic [$clog2(MNV)-1:0]    cfg_max_vol,
  input  logic                      cfg_relu_en,
  output logic                      cfg_ready,
  output logic                      busy,
  output logic                      act_load,
  output logic                      wei_load,
  output logic                      mac_en,
  output logic                      acc_clr,
  output logic                      quant_en,
  output logic                      relu_en,
  output logic                      wb,
  output logic                      done,
  output logic [NW-1:0]             wei_reg_en,
  output logic [$clog2(NW+1)-1:0]   fil_idx,
  output logic [$clog2(MNV)-1:0]    vol_idx
);

  localparam int unsigned OW = $clog2(MNO);
  localparam int unsigned QW = $clog2(Pa * Pw);
  localparam int unsigned GW = $clog2(NW + 1);
  localparam int unsigned VW = $clog2(MNV);
  localparam logic [GW-1:0] NwG = GW'(NW);

  typedef enum logic [2:0] {
    StIdle, StLoadAct, StLoadWei, StMac, StQuant, StRelu, StWb, StDone
  } state_e;

  state_e          state_d, state_q;
  logic [OW-1:0]   op_d, op_q;
  logic [QW-1:0]   qnt_d, qnt_q;
  logic [GW-1:0]   fil_d, fil_q;
  logic [VW-1:0]   vol_d, vol_q;
  logic [OW-1:0]   cfg_ops_d, cfg_ops_q;
  logic [QW-1:0]   cfg_qnt_d, cfg_qnt_q;
  logic [GW-1:0]   cfg_grp_d, cfg_grp_q;
  logic [VW-1:0]   cfg_vol_d, cfg_vol_q;
  logic            cfg_relu_d, cfg_relu_q;
  // {act_load, wei_load, mac_en, acc_clr, quant_en, relu_en, wb, done}
  logic [7:0]      strb_d, strb_q;
  logic [NW-1:0]   wre_d, wre_q;
  logic [GW-1:0]   grp_last;

  // Index of the last active group: 0 behaves as 1, anything above NW saturates to NW.
  always_comb begin
    grp_last = '0;
    if (cfg_grp_q == '0) begin
      grp_last = '0;
    end else if (cfg_grp_q > NwG) begin
      grp_last = NwG - GW'(1);
    end else begin
      grp_last = cfg_grp_q - GW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    qnt_d      = qnt_q;
    fil_d      = fil_q;
    vol_d      = vol_q;
    cfg_ops_d  = cfg_ops_q;
    cfg_qnt_d  = cfg_qnt_q;
    cfg_grp_d  = cfg_grp_q;
    cfg_vol_d  = cfg_vol_q;
    cfg_relu_d = cfg_relu_q;
    strb_d     = strb_q;
    wre_d      = wre_q;

    if (state_q == StIdle && cfg_valid) begin
      cfg_ops_d  = cfg_max_ops;
      cfg_qnt_d  = cfg_max_quant;
      cfg_grp_d  = cfg_fil_groups;
      cfg_vol_d  = cfg_max_vol;
      cfg_relu_d = cfg_relu_en;
    end

    if (core_stall_n) begin
      unique case (state_q)
        StIdle:    if (start) state_d = StLoadAct;
        StLoadAct: state_d = StLoadWei;
        StLoadWei: begin
          state_d = StMac;
          op_d    = '0;
        end
        StMac: begin
          if (op_q == cfg_ops_q) begin
            state_d = StQuant;
            qnt_d   = '0;
          end else begin
            op_d = op_q + OW'(1);
          end
        end
        StQuant: begin
          if (qnt_q == cfg_qnt_q) begin
            state_d = cfg_relu_q ? StRelu : StWb;
          end else begin
            qnt_d = qnt_q + QW'(1);
          end
        end
        StRelu:    state_d = StWb;
        StWb: begin
          if (fil_q < grp_last) begin
            fil_d   = fil_q + GW'(1);
            state_d = StLoadWei;
          end else if (vol_q < cfg_vol_q) begin
            fil_d   = '0;
            vol_d   = vol_q + VW'(1);
            state_d = StLoadAct;
          end else begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
          op_d    = '0;
          qnt_d   = '0;
          fil_d   = '0;
          vol_d   = '0;
        end
        default:   state_d = StIdle;
      endcase

      // Strobes are registered decodes of the state being entered.
      strb_d = {state_d == StLoadAct, state_d == StLoadWei, state_d == StMac,
                state_d == StLoadAct || state_d == StWb, state_d == StQuant,
                state_d == StRelu, state_d == StWb, state_d == StDone};
      for (int i = 0; i < NW; i++) begin
        wre_d[i] = (state_d == StLoadWei) && (fil_d == GW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      qnt_q      <= '0;
      fil_q      <= '0;
      vol_q      <= '0;
      cfg_ops_q  <= '0;
      cfg_qnt_q  <= '0;
      cfg_grp_q  <= '0;
      cfg_vol_q  <= '0;
      cfg_relu_q <= 1'b0;
      strb_q     <= '0;
      wre_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      qnt_q      <= qnt_d;
      fil_q      <= fil_d;
      vol_q      <= vol_d;
      cfg_ops_q  <= cfg_ops_d;
      cfg_qnt_q  <= cfg_qnt_d;
      cfg_grp_q  <= cfg_grp_d;
      cfg_vol_q  <= cfg_vol_d;
      cfg_relu_q <= cfg_relu_d;
      strb_q     <= strb_d;
      wre_q      <= wre_d;
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign {act_load, wei_load, mac_en, acc_clr, quant_en, relu_en, wb, done} = strb_q;
  assign wei_reg_en = wre_q;
  assign fil_idx    = fil_q;
  assign vol_idx    = vol_q;

endmodule

// File: tb/tb_ctrl_unit_param.sv
module tb_ctrl_unit_param;

  logic        clk = 1'b0;
  logic        rst_n, core_stall_n, start, cfg_valid, cfg_relu_en;
  logic [8:0]  cfg_max_ops;
  logic [4:0]  cfg_max_quant;
  logic [3:0]  cfg_fil_groups;
  logic [15:0] cfg_max_vol;
  logic        cfg_ready, busy, act_load, wei_load, mac_en, acc_clr, quant_en, relu_en, wb, done;
  logic [7:0]  wei_reg_en;
  logic [3:0]  fil_idx;
  logic [15:0] vol_idx;

  ctrl_unit_param dut (
    .clk(clk), .rst_n(rst_n), .core_stall_n(core_stall_n), .start(start),
    .cfg_valid(cfg_valid), .cfg_max_ops(cfg_max_ops), .cfg_max_quant(cfg_max_quant),
    .cfg_fil_groups(cfg_fil_groups), .cfg_max_vol(cfg_max_vol), .cfg_relu_en(cfg_relu_en),
    .cfg_ready(cfg_ready), .busy(busy), .act_load(act_load), .wei_load(wei_load),
    .mac_en(mac_en), .acc_clr(acc_clr), .quant_en(quant_en), .relu_en(relu_en), .wb(wb),
    .done(done), .wei_reg_en(wei_reg_en), .fil_idx(fil_idx), .vol_idx(vol_idx)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int c_mac, c_wb, c_relu, c_done;
  logic [7:0] wre_seq[$];
  logic [37:0] exp_q[$];
  logic [37:0] obs;

  assign obs = {cfg_ready, busy, act_load, wei_load, mac_en, acc_clr, quant_en, relu_en, wb,
                done, wei_reg_en, fil_idx, vol_idx};

  localparam int KIdle = 0, KLa = 1, KLw = 2, KMac = 3, KQ = 4, KRelu = 5, KWb = 6, KDone = 7;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Expected output word for one cycle spent in a given phase.
  function automatic logic [37:0] ew(input int k, input int g, input int v);
    logic [7:0] s;
    logic [7:0] wre;
    s   = '0;
    wre = '0;
    if (k == KIdle) return {2'b10, 36'd0};
    case (k)
      KLa:   s = 8'b1001_0000;
      KLw:   begin s = 8'b0100_0000; wre[g] = 1'b1; end
      KMac:  s = 8'b0010_0000;
      KQ:    s = 8'b0000_1000;
      KRelu: s = 8'b0000_0100;
      KWb:   s = 8'b0001_0010;
      KDone: s = 8'b0000_0001;
      default: s = '0;
    endcase
    return {2'b01, s, wre, 4'(g), 16'(v)};
  endfunction

  task automatic build(input int ops, input int qnt, input int grp, input int vol, input int relu);
    int ge;
    ge = (grp == 0) ? 1 : (grp > 8 ? 8 : grp);
    exp_q.delete();
    for (int v = 0; v <= vol; v++) begin
      for (int g = 0; g < ge; g++) begin
        if (g == 0) exp_q.push_back(ew(KLa, 0, v));
        exp_q.push_back(ew(KLw, g, v));
        for (int i = 0; i <= ops; i++) exp_q.push_back(ew(KMac, g, v));
        for (int i = 0; i <= qnt; i++) exp_q.push_back(ew(KQ, g, v));
        if (relu != 0) exp_q.push_back(ew(KRelu, g, v));
        exp_q.push_back(ew(KWb, g, v));
      end
    end
    exp_q.push_back(ew(KDone, ge - 1, vol));
  endtask

  task automatic configure(input int ops, input int qnt, input int grp, input int vol,
                           input int relu);
    @(negedge clk);
    core_stall_n   = 1'b1;
    cfg_valid      = 1'b1;
    cfg_max_ops    = 9'(ops);
    cfg_max_quant  = 5'(qnt);
    cfg_fil_groups = 4'(grp);
    cfg_max_vol    = 16'(vol);
    cfg_relu_en    = relu[0];
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic tally();
    if (mac_en) c_mac++;
    if (wb) c_wb++;
    if (relu_en) c_relu++;
    if (done) c_done++;
    if (wei_load) wre_seq.push_back(wei_reg_en);
  endtask

  // Starts a layer and compares every cycle against the model; a stalled edge must hold.
  task automatic run(input string tag, input int ops, input int qnt, input int grp,
                     input int vol, input int relu, input int stall_pct,
                     input int st_from, input int st_len);
    logic [37:0] prev, e;
    int step;
    logic st;
    build(ops, qnt, grp, vol, relu);
    c_mac = 0; c_wb = 0; c_relu = 0; c_done = 0;
    wre_seq.delete();
    @(negedge clk);
    start = 1'b1;
    core_stall_n = 1'b1;
    cfg_valid = 1'b0;
    @(posedge clk);
    #1;
    prev = exp_q.pop_front();
    chk({tag, "_first"}, 64'(obs), 64'(prev));
    tally();
    start = 1'b0;
    step = 1;
    while (exp_q.size() > 0 && step < 5000) begin
      @(negedge clk);
      if (step >= st_from && step < st_from + st_len) st = 1'b0;
      else st = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      core_stall_n   = st;
      cfg_valid      = 1'($urandom_range(1));
      cfg_max_ops    = 9'($urandom);
      cfg_max_quant  = 5'($urandom);
      cfg_fil_groups = 4'($urandom);
      cfg_max_vol    = 16'($urandom);
      cfg_relu_en    = 1'($urandom);
      @(posedge clk);
      #1;
      e = st ? exp_q.pop_front() : prev;
      chk({tag, "_cyc"}, 64'(obs), 64'(e));
      if (st) tally();
      prev = e;
      step++;
    end
    chk({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    core_stall_n = 1'b1;
    @(posedge clk);
    #1 chk({tag, "_idle"}, 64'(obs), 64'(ew(KIdle, 0, 0)));
  endtask

  initial begin
    rst_n = 1'b0; core_stall_n = 1'b1; start = 1'b0; cfg_valid = 1'b0;
    cfg_max_ops = '0; cfg_max_quant = '0; cfg_fil_groups = '0; cfg_max_vol = '0;
    cfg_relu_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", 64'(obs), 64'(ew(KIdle, 0, 0)));
    @(negedge clk);
    rst_n = 1'b1;

    // Minimum configuration: fixed latency of every phase.
    configure(0, 0, 1, 0, 0);
    run("min", 0, 0, 1, 0, 0, 0, 0, 0);

    // Three groups, two positions, relu on.
    configure(4, 3, 3, 1, 1);
    run("g3", 4, 3, 3, 1, 1, 0, 0, 0);
    chk("g3_wb", 64'(c_wb), 64'd6);
    chk("g3_mac", 64'(c_mac), 64'd30);
    chk("g3_relu", 64'(c_relu), 64'd6);
    chk("g3_done", 64'(c_done), 64'd1);
    chk("g3_wre_n", 64'(wre_seq.size()), 64'd6);
    begin
      logic [7:0] ref_seq [6];
      ref_seq = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04};
      for (int i = 0; i < 6 && i < wre_seq.size(); i++) chk("g3_wre", 64'(wre_seq[i]),
                                                             64'(ref_seq[i]));
    end

    // Group count saturation.
    configure(1, 0, 0, 0, 0);
    run("g0", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("g0_wb", 64'(c_wb), 64'd1);
    configure(0, 1, 12, 0, 0);
    run("g12", 0, 1, 12, 0, 0, 0, 0, 0);
    chk("g12_wb", 64'(c_wb), 64'd8);

    // Five-cycle stall in the middle of MAC.
    configure(9, 1, 1, 0, 0);
    run("stall", 9, 1, 1, 0, 0, 0, 5, 5);
    chk("stall_mac", 64'(c_mac), 64'd10);

    // Randomised configurations with random stalls and ignored cfg writes while busy.
    for (int r = 0; r < 12; r++) begin
      int o, q, g, v, rl;
      o = $urandom_range(5); q = $urandom_range(4); g = $urandom_range(12);
      v = $urandom_range(2); rl = $urandom_range(1);
      configure(o, q, g, v, rl);
      run("rand", o, q, g, v, rl, 25, 0, 0);
      chk("rand_done", 64'(c_done), 64'd1);
    end

    // Reset pulse during QUANT aborts the layer.
    configure(3, 7, 2, 1, 1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    begin
      int n;
      n = 0;
      while (!quant_en && n < 50) begin
        @(posedge clk);
        #1 n++;
      end
      chk("rst_reach_quant", 64'(quant_en), 64'd1);
    end
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 64'(obs), 64'(ew(KIdle, 0, 0)));
    @(posedge clk);
    #1 chk("rst_nodone", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_after", 64'(obs), 64'(ew(KIdle, 0, 0)));
    configure(2, 1, 2, 1, 0);
    run("post_rst", 2, 1, 2, 1, 0, 10, 0, 0);
    chk("post_rst_done", 64'(c_done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
